// File: rtl/vx_pipe_mux.sv
// vx_pipe_mux: pipelined, flow-controlled N:1 data selector.
//
// A radix-RADIX mux tree with a register after every level. Each tree level
// is one pipeline stage. Stage k resolves select digit k, so the low select
// bits are used first. The unconsumed select bits travel with the data.
// Stages collapse bubbles: a stage loads whenever it is empty or when the
// stage after it is loading.
//
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset; clears valid, data and select
//   valid_in   input transfer request
//   ready_in   block can accept an input this cycle (combinational from ready_out)
//   data_in    N packed lanes, lane i at [i*DATAW +: DATAW]
//   sel_in     lane index to forward; indices >= N select zero
//   valid_out  output word valid
//   ready_out  consumer accepts output this cycle
//   data_out   selected lane
module vx_pipe_mux #(
  parameter int DATAW = 32,
  parameter int N     = 8,
  parameter int RADIX = 4,
  parameter int LN    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  output logic               ready_in,
  input  logic [N*DATAW-1:0] data_in,
  input  logic [LN-1:0]      sel_in,
  output logic               valid_out,
  input  logic               ready_out,
  output logic [DATAW-1:0]   data_out
);

  localparam int LR     = $clog2(RADIX);
  localparam int STAGES = (N > 1) ? (LN + LR - 1) / LR : 1;
  localparam int SELW   = STAGES * LR;
  localparam int LEAVES = RADIX ** STAGES;

  logic [STAGES-1:0] vld_q;
  logic [STAGES:0]   vld_pipe;   // [0] = valid_in, [k+1] = stage k valid
  logic [STAGES-1:0] en;
  logic [SELW-1:0]   sel_pad;

  assign vld_pipe  = {vld_q, valid_in};
  assign sel_pad   = SELW'(sel_in);
  assign ready_in  = en[0];
  assign valid_out = vld_pipe[STAGES];

  // Flattened form of en[k] = !vld[k] || en[k+1]: stage k may load unless it
  // and every stage downstream is full while the consumer stalls.
  for (genvar k = 0; k < STAGES; k++) begin : g_en
    assign en[k] = ready_out | ~(&vld_q[STAGES-1:k]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (en[k]) vld_q[k] <= vld_pipe[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int NO = RADIX ** (STAGES - 1 - k);  // mux groups in this level
    localparam int SW = SELW - k * LR;              // select bits entering stage

    logic [SW-1:0]             sin;
    logic [NO-1:0][DATAW-1:0]  mux_d;
    logic [NO-1:0][DATAW-1:0]  dat_q;

    if (k == 0) begin : g_sin0
      assign sin = sel_pad;
    end else begin : g_sinn
      assign sin = g_stg[k-1].g_sel.sel_q;
    end

    if (N == 1) begin : g_one
      // Single handshake register; the select has no meaning.
      logic unused_sel;
      assign unused_sel = ^sin;
      assign mux_d[0]   = data_in;
    end else begin : g_tree
      logic [NO*RADIX-1:0][DATAW-1:0] din;
      if (k == 0) begin : g_leaf
        // Pad to a full RADIX^STAGES tree; padded leaves read as zero.
        always_comb begin
          din        = '0;
          din[N-1:0] = data_in;
        end
      end else begin : g_prev
        assign din = g_stg[k-1].dat_q;
      end
      for (genvar j = 0; j < NO; j++) begin : g_grp
        logic [RADIX-1:0][DATAW-1:0] cand;
        assign cand     = din[j*RADIX +: RADIX];
        assign mux_d[j] = cand[sin[LR-1:0]];
      end
    end

    // Remaining select digits ride along for the later levels.
    if (k < STAGES - 1) begin : g_sel
      logic [SW-LR-1:0] sel_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                      sel_q <= '0;
        else if (en[k] && vld_pipe[k])  sel_q <= sin[SW-1:LR];
      end
    end

    // Data loads only for a real word; bubbles just clear the valid bit.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                      dat_q <= '0;
      else if (en[k] && vld_pipe[k])  dat_q <= mux_d;
    end
  end

  assign data_out = g_stg[STAGES-1].dat_q[0];

endmodule

// File: tb/tb_vx_pipe_mux.sv
module tb_vx_pipe_mux;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // A: N=8, RADIX=4 (2 stages), lanes 32'h100+i
  logic            a_vin, a_rin, a_vout, a_rdy;
  logic [8*32-1:0] a_din;
  logic [2:0]      a_sel;
  logic [31:0]     a_dout;
  logic [31:0]     a_q[$];

  // B: N=6, RADIX=2 (3 stages), lanes 32'h200+i
  logic            b_vin, b_rin, b_vout, b_rdy;
  logic [6*32-1:0] b_din;
  logic [2:0]      b_sel;
  logic [31:0]     b_dout;
  logic [31:0]     b_q[$];

  // C: N=1
  logic            c_vin, c_rin, c_vout, c_rdy;
  logic [31:0]     c_din;
  logic [0:0]      c_sel;
  logic [31:0]     c_dout;
  logic [31:0]     c_q[$];

  vx_pipe_mux #(.DATAW(32), .N(8), .RADIX(4)) u_a (
    .clk(clk), .reset(reset), .valid_in(a_vin), .ready_in(a_rin), .data_in(a_din),
    .sel_in(a_sel), .valid_out(a_vout), .ready_out(a_rdy), .data_out(a_dout));

  vx_pipe_mux #(.DATAW(32), .N(6), .RADIX(2)) u_b (
    .clk(clk), .reset(reset), .valid_in(b_vin), .ready_in(b_rin), .data_in(b_din),
    .sel_in(b_sel), .valid_out(b_vout), .ready_out(b_rdy), .data_out(b_dout));

  vx_pipe_mux #(.DATAW(32), .N(1), .RADIX(4)) u_c (
    .clk(clk), .reset(reset), .valid_in(c_vin), .ready_in(c_rin), .data_in(c_din),
    .sel_in(c_sel), .valid_out(c_vout), .ready_out(c_rdy), .data_out(c_dout));

  // Drivers: set inputs on the falling edge, then note whether the coming
  // rising edge will take the word and push its expected result.
  task automatic drive_a(input logic v, input logic [2:0] s, input logic r, output bit acc);
    @(negedge clk);
    a_vin = v; a_sel = s; a_rdy = r;
    #1;
    acc = v && a_rin;
    if (acc) a_q.push_back(32'h100 + 32'(s));
  endtask

  task automatic drive_b(input logic v, input logic [2:0] s, input logic r, output bit acc);
    @(negedge clk);
    b_vin = v; b_sel = s; b_rdy = r;
    #1;
    acc = v && b_rin;
    if (acc) b_q.push_back((s < 3'd6) ? 32'h200 + 32'(s) : 32'h0);
  endtask

  task automatic drive_c(input logic v, input logic [31:0] d, input logic r, output bit acc);
    @(negedge clk);
    c_vin = v; c_din = d; c_rdy = r;
    #1;
    acc = v && c_rin;
    if (acc) c_q.push_back(d);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    a_vin = 0; a_sel = 0; a_rdy = 1;
    b_vin = 0; b_sel = 0; b_rdy = 1;
    c_vin = 0; c_sel = 0; c_rdy = 1; c_din = 0;
    for (int i = 0; i < 8; i++) a_din[i*32 +: 32] = 32'h100 + i;
    for (int i = 0; i < 6; i++) b_din[i*32 +: 32] = 32'h200 + i;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (a_vout !== 1'b0 || a_dout !== 32'h0) begin
      bad++; $display("FAIL reset_a_out: got v=%b d=%h want v=0 d=0", a_vout, a_dout);
    end
    total++;
    if (b_vout !== 1'b0 || c_vout !== 1'b0 || b_dout !== 32'h0 || c_dout !== 32'h0) begin
      bad++; $display("FAIL reset_bc_out: got vb=%b vc=%b db=%h dc=%h want zeros", b_vout, c_vout, b_dout, c_dout);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if ({a_rin, b_rin, c_rin} !== 3'b111 || {a_vout, b_vout, c_vout} !== 3'b000) begin
      bad++; $display("FAIL reset_release: got rdy=%b vld=%b want rdy=111 vld=000", {a_rin, b_rin, c_rin}, {a_vout, b_vout, c_vout});
    end
  endtask

  task automatic test_single;
    bit acc;
    logic [31:0] e;
    for (int t = 0; t < 5; t++) begin
      drive_a(t == 0, 3'd5, 1'b1, acc);
      total++;
      if (a_vout !== (t == 2)) begin
        bad++; $display("FAIL single_valid t=%0d: got %b want %b", t, a_vout, (t == 2));
      end
      if (a_vout && a_rdy) begin
        total++;
        if (a_q.size() == 0) begin bad++; $display("FAIL single_extra: got %h want none", a_dout); end
        else begin
          e = a_q.pop_front();
          if (a_dout !== e) begin bad++; $display("FAIL single_data: got %h want %h", a_dout, e); end
        end
      end
    end
  endtask

  task automatic test_stream;
    bit acc;
    logic [31:0] e;
    for (int t = 0; t < 12; t++) begin
      drive_a(t < 8, 3'(t), 1'b1, acc);
      if (t < 8) begin
        total++;
        if (a_rin !== 1'b1) begin bad++; $display("FAIL stream_ready t=%0d: got %b want 1", t, a_rin); end
      end
      total++;
      if (a_vout !== (t >= 2 && t < 10)) begin
        bad++; $display("FAIL stream_valid t=%0d: got %b want %b", t, a_vout, (t >= 2 && t < 10));
      end
      if (a_vout && a_rdy) begin
        total++;
        if (a_q.size() == 0) begin bad++; $display("FAIL stream_extra: got %h want none", a_dout); end
        else begin
          e = a_q.pop_front();
          if (a_dout !== e) begin bad++; $display("FAIL stream_data t=%0d: got %h want %h", t, a_dout, e); end
        end
      end
    end
    total++;
    if (a_q.size() != 0) begin bad++; $display("FAIL stream_left: got %0d want 0", a_q.size()); end
  endtask

  task automatic test_backpressure;
    bit acc;
    int sent = 0;
    logic [2:0] words[4];
    logic [31:0] e;
    words = '{3'd1, 3'd3, 3'd6, 3'd2};
    for (int t = 0; t < 6; t++) begin
      drive_a(sent < 4, words[sent % 4], 1'b0, acc);
      if (acc) sent++;
      total++;
      if (a_rin !== (t < 2)) begin bad++; $display("FAIL bp_ready t=%0d: got %b want %b", t, a_rin, (t < 2)); end
      if (t >= 2) begin
        total++;
        if (a_vout !== 1'b1 || a_dout !== 32'h101) begin
          bad++; $display("FAIL bp_frozen t=%0d: got v=%b d=%h want v=1 d=00000101", t, a_vout, a_dout);
        end
      end
    end
    total++;
    if (sent != 2) begin bad++; $display("FAIL bp_accepted: got %0d want 2", sent); end
    for (int t = 0; t < 12; t++) begin
      drive_a(sent < 4, words[sent % 4], 1'b1, acc);
      if (acc) sent++;
      if (a_vout && a_rdy) begin
        total++;
        if (a_q.size() == 0) begin bad++; $display("FAIL bp_dup: got %h want none", a_dout); end
        else begin
          e = a_q.pop_front();
          if (a_dout !== e) begin bad++; $display("FAIL bp_order: got %h want %h", a_dout, e); end
        end
      end
    end
    total++;
    if (sent != 4 || a_q.size() != 0) begin
      bad++; $display("FAIL bp_drain: got sent=%0d left=%0d want sent=4 left=0", sent, a_q.size());
    end
  endtask

  task automatic test_garbage;
    bit acc;
    for (int t = 0; t < 4; t++) begin
      a_din = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      drive_a(1'b0, 3'($urandom_range(7)), 1'b1, acc);
      total++;
      if (a_vout !== 1'b0) begin bad++; $display("FAIL garbage_valid t=%0d: got %b want 0", t, a_vout); end
    end
    for (int i = 0; i < 8; i++) a_din[i*32 +: 32] = 32'h100 + i;
  endtask

  task automatic test_pad;
    bit acc;
    logic [2:0] sels[4];
    logic [31:0] e;
    sels = '{3'd5, 3'd7, 3'd0, 3'd6};
    for (int t = 0; t < 9; t++) begin
      drive_b(t < 4, sels[t % 4], 1'b1, acc);
      total++;
      if (b_vout !== (t >= 3 && t < 7)) begin
        bad++; $display("FAIL pad_valid t=%0d: got %b want %b", t, b_vout, (t >= 3 && t < 7));
      end
      if (b_vout && b_rdy) begin
        total++;
        if (b_q.size() == 0) begin bad++; $display("FAIL pad_extra: got %h want none", b_dout); end
        else begin
          e = b_q.pop_front();
          if (b_dout !== e) begin bad++; $display("FAIL pad_data t=%0d: got %h want %h", t, b_dout, e); end
        end
      end
    end
  endtask

  task automatic test_n1;
    bit acc;
    logic [31:0] e;
    drive_c(1'b1, 32'hDEAD_BEEF, 1'b0, acc);
    total++;
    if (acc !== 1'b1) begin bad++; $display("FAIL n1_accept: got %b want 1", acc); end
    for (int t = 0; t < 2; t++) begin
      drive_c(1'b1, 32'h1234_5678, 1'b0, acc);
      total++;
      if (c_vout !== 1'b1 || c_dout !== 32'hDEAD_BEEF || c_rin !== 1'b0) begin
        bad++; $display("FAIL n1_hold t=%0d: got v=%b d=%h r=%b want v=1 d=deadbeef r=0", t, c_vout, c_dout, c_rin);
      end
    end
    drive_c(1'b0, 32'h0, 1'b1, acc);
    total++;
    if (c_q.size() == 0 || !c_vout) begin
      bad++; $display("FAIL n1_out: got v=%b q=%0d want v=1 q=1", c_vout, c_q.size());
    end else begin
      e = c_q.pop_front();
      if (c_dout !== e) begin bad++; $display("FAIL n1_data: got %h want %h", c_dout, e); end
    end
    drive_c(1'b0, 32'h0, 1'b1, acc);
    total++;
    if (c_vout !== 1'b0) begin bad++; $display("FAIL n1_empty: got %b want 0", c_vout); end
  endtask

  task automatic test_reset_mid;
    bit acc;
    drive_a(1'b1, 3'd3, 1'b1, acc);
    drive_a(1'b1, 3'd4, 1'b1, acc);
    @(negedge clk);
    a_vin = 1'b0;
    #1;
    total++;
    if (a_vout !== 1'b1) begin bad++; $display("FAIL rmid_inflight: got %b want 1", a_vout); end
    #1 reset = 1'b1;
    #1;
    total++;
    if (a_vout !== 1'b0 || a_dout !== 32'h0) begin
      bad++; $display("FAIL rmid_clear: got v=%b d=%h want v=0 d=0", a_vout, a_dout);
    end
    a_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      drive_a(1'b0, 3'd0, 1'b1, acc);
      total++;
      if (a_vout !== 1'b0 || a_rin !== 1'b1) begin
        bad++; $display("FAIL rmid_stale t=%0d: got v=%b r=%b want v=0 r=1", t, a_vout, a_rin);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_garbage();
    test_pad();
    test_n1();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_pipe_mux.md
Name: vx_pipe_mux

Overview:
- Pipelined, flow-controlled N:1 data selector for wide, high-fan-in selection that cannot close timing as a single combinational mux.
- Builds a radix-RADIX mux tree and registers each tree level.
- Carries a valid/ready handshake through the tree so upstream arbiters and downstream consumers can stall it.
- Used in the core's writeback, LSU response and cache bank output selection paths.

Parameters:
DATAW, 32, width of each data lane in bits (>=1)
N, 8, number of input lanes (>=1)
RADIX, 4, fan-in per tree level; power of two, >=2
LN, LOG2UP(N), width of the select input (derived; do not override)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
valid_in  input  1  input transfer request
ready_in  output  1  block can accept an input this cycle
data_in  input  N*DATAW  packed lanes; lane i occupies bits [i*DATAW +: DATAW]
sel_in  input  LN  lane index to forward
valid_out  output  1  output holds a valid selected word
ready_out  input  1  consumer accepts output this cycle
data_out  output  DATAW  selected lane

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset. While reset is high, all stage valid bits, stage data and stage select registers clear to 0. Hence valid_out=0, data_out=0, and ready_in=1 from the first cycle after reset deasserts. Reset asserted mid-operation discards all in-flight words with no partial output.
- Stage count: LR = log2(RADIX). STAGES = N>1 ? ceil(LN/LR) : 1. Example: N=8, RADIX=4 gives 2 stages; N=16, RADIX=4 gives 2; N=2 gives 1.
- Stage k (k = 0..STAGES-1):
  - Consumes sel bits [k*LR +: LR]; the top stage uses only the remaining bits.
  - Each mux group picks one of RADIX candidates and registers the result.
  - Unused select bits are registered alongside the data for later stages.
- N not a power of RADIX: the tree is zero-padded to RADIX^STAGES leaves. Any sel_in >= N yields data_out = 0 with normal valid flow; this is not an error.
- N == 1: sel_in is unused. The block is a single handshake register, and data_out equals the lane captured on transfer.
- Handshake:
  - Input transfer occurs when valid_in && ready_in.
  - Output transfer occurs when valid_out && ready_out.
  - data_out and valid_out remain stable while valid_out=1 and ready_out=0.
- Pipeline advance (per stage, bubble-collapsing):
  - stage_en[k] = !valid[k] || stage_en[k+1], with stage_en[STAGES] = ready_out.
  - ready_in = stage_en[0].
  - When stage_en[k] is high, valid[k] takes the previous stage's valid (valid_in for k=0), and data/sel update. When it is low, the stage holds.
  - data/sel registers may skip loading when the incoming valid is 0. valid must still clear.
- Latency and throughput:
  - Exactly STAGES cycles from input transfer to valid_out with no backpressure.
  - Sustains 1 transfer/cycle when ready_out is held at 1.
  - Holds up to STAGES words in flight with no loss or duplication under any ready_out pattern.
  - Order is preserved.
- Simultaneous events: with all stages full and ready_out=1, an input is accepted in the same cycle the oldest word leaves. No combinational path from valid_in to valid_out. ready_in depends combinationally on ready_out through the stage_en chain; this is the accepted design.
- valid_in=0 with garbage data_in/sel_in: no effect on outputs.

Test Plan:
- Reset release, N=8, RADIX=4, DATAW=32, ready_out=1: lanes = 32'h100+i. Send sel_in=5 with valid_in=1 for one cycle. Expect valid_out=1 exactly 2 cycles later with data_out=32'h105, then valid_out=0.
- Streaming sel_in = 0,1,...,7 back-to-back with ready_out=1: expect outputs 32'h100..32'h107 on 8 consecutive cycles starting at cycle 2, and ready_in=1 throughout.
- Backpressure: stream 4 words while ready_out=0. Expect ready_in to fall after 2 accepted words and data_out to stay frozen on the first word. Raise ready_out and expect all 4 words in order with no drops or duplicates.
- N=6, RADIX=2 (3 stages): sel_in=5 gives lane 5 after 3 cycles. sel_in=7 gives data_out=0 with valid_out=1.
- N=1: data_in=32'hDEAD_BEEF with valid_in=1 gives valid_out=1 and data_out=32'hDEAD_BEEF next cycle. With ready_out=0, the value holds and ready_in=0.
- Reset asserted asynchronously mid-cycle with 2 words in flight: valid_out and data_out are 0 immediately. After release, no stale word appears and ready_in=1.
